// File: rtl/multimode_counter_game_p.sv
// ---------------------------------------------------------------------------
// multimode_counter_game_p
//
// Parametrised up/down counter game. A WIDTH-bit counter steps by a small or
// large amount, up or down, selected by a 2-bit mode. Arriving at MAX scores
// a win and arriving at zero scores a loss. The first tally to reach
// GAME_LIMIT ends the game, and the block then freezes until reset.
//
// Optional feature macro: COUNTER_SATURATE_EN
//   defined   -> counting clamps at MAX / 0 instead of wrapping
//   undefined -> counting wraps modulo 2^WIDTH
//   Loads are never clamped.
//
// Ports:
//   clk         in   single clock, all state changes on posedge
//   reset       in   synchronous active-low reset
//   enable      in   count enable (a load is still accepted when low)
//   init_load   in   load strobe, has priority over enable
//   initvalue   in   [WIDTH]   load value
//   up_down     in   [2]       00 +small, 01 +large, 10 -small, 11 -large
//   counter     out  [WIDTH]   current count (registered)
//   winner      out  one-cycle pulse, counter has just entered MAX
//   loser       out  one-cycle pulse, counter has just entered 0
//   gameover    out  high from the deciding edge until reset
//   who         out  [2]       00 none, 10 winner decided, 01 loser decided
//   win_tally   out  [TALLY_W] wins so far (saturating)
//   lose_tally  out  [TALLY_W] losses so far (saturating)
// ---------------------------------------------------------------------------
module multimode_counter_game_p #(
    parameter int WIDTH      = 4,
    parameter int STEP_SMALL = 1,
    parameter int STEP_LARGE = 2,
    parameter int GAME_LIMIT = 15,
    parameter int TALLY_W    = $clog2(GAME_LIMIT + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               init_load,
    input  logic [WIDTH-1:0]   initvalue,
    input  logic [1:0]         up_down,
    output logic [WIDTH-1:0]   counter,
    output logic               winner,
    output logic               loser,
    output logic               gameover,
    output logic [1:0]         who,
    output logic [TALLY_W-1:0] win_tally,
    output logic [TALLY_W-1:0] lose_tally
);

    localparam logic       ST_PLAY = 1'b0;
    localparam logic       ST_OVER = 1'b1;

    localparam logic [WIDTH-1:0]   MAX_VAL = {WIDTH{1'b1}};
    localparam logic [WIDTH:0]     STEP_S  = (WIDTH + 1)'(STEP_SMALL);
    localparam logic [WIDTH:0]     STEP_L  = (WIDTH + 1)'(STEP_LARGE);
    localparam logic [TALLY_W-1:0] LIMIT_T = TALLY_W'(GAME_LIMIT);
    localparam logic [TALLY_W-1:0] ONE_T   = TALLY_W'(1);

    logic             state;
    logic [WIDTH:0]   step;
    logic [WIDTH:0]   up_sum;
    logic [WIDTH:0]   down_diff;
    logic [WIDTH-1:0] next_count;
    logic             hit_max;
    logic             hit_zero;

    // Next count in PLAY. The extra top bit of up_sum/down_diff is the
    // carry/borrow; it is discarded for wrap and used to clamp when saturating.
    always_comb begin
        step       = up_down[0] ? STEP_L : STEP_S;
        up_sum     = {1'b0, counter} + step;
        down_diff  = {1'b0, counter} - step;
        next_count = counter;
        if (init_load) begin
            next_count = initvalue;
        end else if (enable) begin
            if (!up_down[1]) begin
`ifdef COUNTER_SATURATE_EN
                next_count = up_sum[WIDTH] ? MAX_VAL : up_sum[WIDTH-1:0];
`else
                next_count = up_sum[WIDTH-1:0];
`endif
            end else begin
`ifdef COUNTER_SATURATE_EN
                next_count = down_diff[WIDTH] ? '0 : down_diff[WIDTH-1:0];
`else
                next_count = down_diff[WIDTH-1:0];
`endif
            end
        end
    end

    // Entry detection: only a change into MAX or 0 scores, never a hold.
    assign hit_max  = (next_count == MAX_VAL) && (counter != MAX_VAL);
    assign hit_zero = (next_count == '0) && (counter != '0);

    // Registered game state. The deciding tally increment, gameover, who and
    // the move to OVER all happen on the same edge as the pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_PLAY;
            counter    <= '0;
            winner     <= 1'b0;
            loser      <= 1'b0;
            gameover   <= 1'b0;
            who        <= 2'b00;
            win_tally  <= '0;
            lose_tally <= '0;
        end else if (state == ST_PLAY) begin
            counter <= next_count;
            winner  <= hit_max;
            loser   <= hit_zero;
            if (hit_max && (win_tally != LIMIT_T)) begin
                win_tally <= win_tally + ONE_T;
                if ((win_tally + ONE_T) == LIMIT_T) begin
                    gameover <= 1'b1;
                    who      <= 2'b10;
                    state    <= ST_OVER;
                end
            end
            if (hit_zero && (lose_tally != LIMIT_T)) begin
                lose_tally <= lose_tally + ONE_T;
                if ((lose_tally + ONE_T) == LIMIT_T) begin
                    gameover <= 1'b1;
                    who      <= 2'b01;
                    state    <= ST_OVER;
                end
            end
        end else begin
            winner <= 1'b0;
            loser  <= 1'b0;
        end
    end

endmodule
